memory_access_stage: RTL and testbench

- uDLX MEM pipeline stage. It consumes the execute stage results (ALU result/address, store data, destination register) through the EX/MEM register.
- Performs byte/half/word loads and stores over a req/ack data-memory port, with a wait-state stall and a timeout.
- Produces the EX/MEM and WB forwarding/write-back triples that the execute stage consumes.

---
 rtl/memory_access_stage.sv | 199 +++++++++++++++++++
 tb/tb_memory_access_stage.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access_stage.sv
// memory_access_stage: uDLX MEM pipeline stage.
//
// Purpose: holds the EX/MEM register and runs byte/half/word loads and
// stores over a req/ack data-memory port. A slow memory stalls the pipeline
// until it acks, and an access that gets no ack within TIMEOUT_CYCLES is
// aborted. The stage also drives the EX/MEM forwarding triple and the
// MEM/WB write-back triple.
//
// Ports:
//   clk, rst               clock (rising edge), asynchronous active-high reset
//   ex_valid_in .. mem_signed_in
//                          instruction fields from the execute stage
//   stall_out              freezes IF/ID/EX and holds EX/MEM
//   dmem_*                 data-memory request/response port
//   ex_mem_reg_*_out       EX/MEM forwarding triple (loads are excluded)
//   wb_reg_*_out           MEM/WB write-back triple
//   misaligned_out         one-cycle pulse when a misaligned access is dropped
//   bus_error_out          one-cycle pulse when an access times out
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no access outstanding, dmem_req_out low
// BUSY  | access held on the dmem port, waiting for ack or timeout
module memory_access_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ex_valid_in,
  input  logic [DATA_WIDTH-1:0]     alu_data_in,
  input  logic [DATA_WIDTH-1:0]     mem_data_in,
  input  logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_in,
  input  logic                      reg_wr_ena_in,
  input  logic                      mem_rd_in,
  input  logic                      mem_wr_in,
  input  logic [1:0]                mem_size_in,
  input  logic                      mem_signed_in,
  output logic                      stall_out,
  output logic                      dmem_req_out,
  output logic                      dmem_we_out,
  output logic [DATA_WIDTH-1:0]     dmem_addr_out,
  output logic [DATA_WIDTH-1:0]     dmem_wdata_out,
  output logic [DATA_WIDTH/8-1:0]   dmem_be_out,
  input  logic [DATA_WIDTH-1:0]     dmem_rdata_in,
  input  logic                      dmem_ack_in,
  output logic [DATA_WIDTH-1:0]     ex_mem_reg_data_out,
  output logic [REG_ADDR_WIDTH-1:0] ex_mem_reg_addr_out,
  output logic                      ex_mem_reg_wr_ena_out,
  output logic [DATA_WIDTH-1:0]     wb_reg_data_out,
  output logic [REG_ADDR_WIDTH-1:0] wb_reg_addr_out,
  output logic                      wb_reg_wr_ena_out,
  output logic                      misaligned_out,
  output logic                      bus_error_out
);

  localparam int BW = DATA_WIDTH / 8;
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                    state;
  logic [CW-1:0]             count;

  // EX/MEM register
  logic                      em_valid;
  logic [DATA_WIDTH-1:0]     em_alu;
  logic [REG_ADDR_WIDTH-1:0] em_reg_addr;
  logic                      em_reg_wr_ena;
  logic                      em_rd;
  logic                      em_wr;
  logic [1:0]                em_size;
  logic                      em_signed;

  logic                      in_mem;
  logic                      in_misaligned;
  logic                      in_access;
  logic                      in_keep;
  logic                      timeout_hit;
  logic                      abort;
  logic [BW-1:0]             in_be;
  logic [DATA_WIDTH-1:0]     in_wdata;
  logic [DATA_WIDTH-1:0]     lane;
  logic [DATA_WIDTH-1:0]     load_data;

  // Incoming instruction classification
  always_comb begin
    in_mem        = ex_valid_in & (mem_rd_in | mem_wr_in);
    in_misaligned = in_mem & (((mem_size_in == 2'b01) & alu_data_in[0]) |
                              (mem_size_in[1] & (alu_data_in[1:0] != 2'b00)));
    in_access     = in_mem & ~in_misaligned;
    // Misaligned accesses enter EX/MEM as bubbles
    in_keep       = ex_valid_in & ~in_misaligned;
  end

  always_comb begin
    in_be    = '1;
    in_wdata = mem_data_in;
    case (mem_size_in)
      2'b00: begin
        in_be    = BW'(1) << alu_data_in[1:0];
        in_wdata = {BW{mem_data_in[7:0]}};
      end
      2'b01: begin
        in_be    = BW'(3) << alu_data_in[1:0];
        in_wdata = {(BW/2){mem_data_in[15:0]}};
      end
      default: begin
        in_be    = '1;
        in_wdata = mem_data_in;
      end
    endcase
  end

  // Load lane extraction from the access currently held in EX/MEM
  always_comb begin
    lane      = dmem_rdata_in >> {em_alu[1:0], 3'b000};
    load_data = dmem_rdata_in;
    case (em_size)
      2'b00:   load_data = {{(DATA_WIDTH-8){em_signed & lane[7]}}, lane[7:0]};
      2'b01:   load_data = {{(DATA_WIDTH-16){em_signed & lane[15]}}, lane[15:0]};
      default: load_data = dmem_rdata_in;
    endcase
  end

  always_comb begin
    timeout_hit = (count == CW'(TIMEOUT_CYCLES - 1));
    stall_out   = (state == BUSY) & ~dmem_ack_in & ~timeout_hit;
    abort       = (state == BUSY) & ~dmem_ack_in & timeout_hit;
  end

  assign ex_mem_reg_data_out   = em_alu;
  assign ex_mem_reg_addr_out   = em_reg_addr;
  assign ex_mem_reg_wr_ena_out = em_valid & em_reg_wr_ena & ~em_rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      count             <= '0;
      em_valid          <= 1'b0;
      em_alu            <= '0;
      em_reg_addr       <= '0;
      em_reg_wr_ena     <= 1'b0;
      em_rd             <= 1'b0;
      em_wr             <= 1'b0;
      em_size           <= 2'b00;
      em_signed         <= 1'b0;
      dmem_req_out      <= 1'b0;
      dmem_we_out       <= 1'b0;
      dmem_addr_out     <= '0;
      dmem_wdata_out    <= '0;
      dmem_be_out       <= '0;
      wb_reg_data_out   <= '0;
      wb_reg_addr_out   <= '0;
      wb_reg_wr_ena_out <= 1'b0;
      misaligned_out    <= 1'b0;
      bus_error_out     <= 1'b0;
    end else begin
      misaligned_out <= ~stall_out & in_misaligned;
      bus_error_out  <= abort;
      if (!stall_out) begin
        em_valid      <= in_keep;
        em_alu        <= alu_data_in;
        em_reg_addr   <= reg_wr_addr_in;
        em_reg_wr_ena <= in_keep & reg_wr_ena_in;
        em_rd         <= in_keep & mem_rd_in;
        em_wr         <= in_keep & mem_wr_in;
        em_size       <= mem_size_in;
        em_signed     <= mem_signed_in;

        // A load in EX/MEM only reaches this edge on ack or abort
        wb_reg_data_out   <= em_rd ? load_data : em_alu;
        wb_reg_addr_out   <= em_reg_addr;
        wb_reg_wr_ena_out <= em_valid & em_reg_wr_ena & ~em_wr & ~abort;

        if (in_access) begin
          state          <= BUSY;
          count          <= '0;
          dmem_req_out   <= 1'b1;
          dmem_we_out    <= mem_wr_in;
          dmem_addr_out  <= {alu_data_in[DATA_WIDTH-1:2], 2'b00};
          dmem_be_out    <= in_be;
          dmem_wdata_out <= in_wdata;
        end else begin
          state        <= IDLE;
          count        <= '0;
          dmem_req_out <= 1'b0;
          dmem_we_out  <= 1'b0;
        end
      end else begin
        // Stall cycles never write back, so a held result is written once
        wb_reg_wr_ena_out <= 1'b0;
        count             <= count + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// tb_memory_access_stage: directed and randomized checks of the MEM stage
// against a behavioural model of the load/store rules.
module tb_memory_access_stage;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid_in = 1'b0;
  logic [31:0] alu_data_in = '0;
  logic [31:0] mem_data_in = '0;
  logic [4:0]  reg_wr_addr_in = '0;
  logic        reg_wr_ena_in = 1'b0;
  logic        mem_rd_in = 1'b0;
  logic        mem_wr_in = 1'b0;
  logic [1:0]  mem_size_in = 2'b00;
  logic        mem_signed_in = 1'b0;
  logic        stall_out;
  logic        dmem_req_out;
  logic        dmem_we_out;
  logic [31:0] dmem_addr_out;
  logic [31:0] dmem_wdata_out;
  logic [3:0]  dmem_be_out;
  logic [31:0] dmem_rdata_in = '0;
  logic        dmem_ack_in = 1'b0;
  logic [31:0] ex_mem_reg_data_out;
  logic [4:0]  ex_mem_reg_addr_out;
  logic        ex_mem_reg_wr_ena_out;
  logic [31:0] wb_reg_data_out;
  logic [4:0]  wb_reg_addr_out;
  logic        wb_reg_wr_ena_out;
  logic        misaligned_out;
  logic        bus_error_out;

  int n_cmp  = 0;
  int n_fail = 0;

  memory_access_stage #(
    .DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .ex_valid_in(ex_valid_in), .alu_data_in(alu_data_in),
    .mem_data_in(mem_data_in), .reg_wr_addr_in(reg_wr_addr_in),
    .reg_wr_ena_in(reg_wr_ena_in), .mem_rd_in(mem_rd_in),
    .mem_wr_in(mem_wr_in), .mem_size_in(mem_size_in),
    .mem_signed_in(mem_signed_in), .stall_out(stall_out),
    .dmem_req_out(dmem_req_out), .dmem_we_out(dmem_we_out),
    .dmem_addr_out(dmem_addr_out), .dmem_wdata_out(dmem_wdata_out),
    .dmem_be_out(dmem_be_out), .dmem_rdata_in(dmem_rdata_in),
    .dmem_ack_in(dmem_ack_in),
    .ex_mem_reg_data_out(ex_mem_reg_data_out),
    .ex_mem_reg_addr_out(ex_mem_reg_addr_out),
    .ex_mem_reg_wr_ena_out(ex_mem_reg_wr_ena_out),
    .wb_reg_data_out(wb_reg_data_out), .wb_reg_addr_out(wb_reg_addr_out),
    .wb_reg_wr_ena_out(wb_reg_wr_ena_out),
    .misaligned_out(misaligned_out), .bus_error_out(bus_error_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference rules expressed arithmetically
  function automatic logic [31:0] ref_be(input logic [1:0] sz, input int a);
    if (sz == 0) return 32'(1 << a);
    if (sz == 1) return 32'(3 << a);
    return 32'd15;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 0) return (d % 256) * 32'h01010101;
    if (sz == 1) return (d % 65536) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input int a,
                                           input logic sgn, input logic [31:0] r);
    logic [31:0] v;
    v = r >> (a * 8);
    if (sz == 0) begin
      v = v % 256;
      if (sgn && v >= 128) v = v - 256;
    end else if (sz == 1) begin
      v = v % 65536;
      if (sgn && v >= 32768) v = v - 65536;
    end else begin
      v = r;
    end
    return v;
  endfunction

  task automatic bubble_inputs();
    ex_valid_in   = 1'b0;
    reg_wr_ena_in = 1'b0;
    mem_rd_in     = 1'b0;
    mem_wr_in     = 1'b0;
  endtask

  task automatic drive_op(input int kind, input logic [1:0] sz, input logic [31:0] addr,
                          input logic [31:0] data, input logic [4:0] rd, input logic sgn);
    ex_valid_in    = 1'b1;
    alu_data_in    = addr;
    mem_data_in    = data;
    reg_wr_addr_in = rd;
    reg_wr_ena_in  = (kind != 2);
    mem_rd_in      = (kind == 1);
    mem_wr_in      = (kind == 2);
    mem_size_in    = sz;
    mem_signed_in  = sgn;
  endtask

  // kind: 0 ALU, 1 load, 2 store. lat = BUSY cycles before ack (>= TO means never).
  task automatic do_op(input int kind, input logic [1:0] sz, input logic [31:0] addr,
                       input logic [31:0] data, input logic [4:0] rd, input logic sgn,
                       input int lat, input logic [31:0] rdat);
    int a;
    logic mis;
    logic timed_out;
    a = int'(addr % 4);
    mis = (kind != 0) && ((sz == 1 && (a % 2) == 1) || (sz >= 2 && a != 0));
    drive_op(kind, sz, addr, data, rd, sgn);
    dmem_ack_in = (kind == 0) ? 1'($urandom % 2) : 1'b0;   // ack while IDLE is ignored
    @(posedge clk); @(negedge clk);
    bubble_inputs();
    dmem_ack_in = 1'b0;
    #1;
    chk("misaligned_pulse", 32'(misaligned_out), 32'(mis));
    chk("fwd_ena", 32'(ex_mem_reg_wr_ena_out), (kind == 0) ? 32'd1 : 32'd0);
    if (kind == 0 || mis) begin
      if (kind == 0) begin
        chk("fwd_data", ex_mem_reg_data_out, addr);
        chk("fwd_addr", 32'(ex_mem_reg_addr_out), 32'(rd));
      end
      chk("no_req", 32'(dmem_req_out), 32'd0);
      chk("no_stall", 32'(stall_out), 32'd0);
      @(posedge clk); @(negedge clk); #1;
      chk("wb_ena", 32'(wb_reg_wr_ena_out), (kind == 0) ? 32'd1 : 32'd0);
      if (kind == 0) begin
        chk("wb_data", wb_reg_data_out, addr);
        chk("wb_addr", 32'(wb_reg_addr_out), 32'(rd));
      end
      chk("misaligned_clear", 32'(misaligned_out), 32'd0);
      return;
    end
    chk("req", 32'(dmem_req_out), 32'd1);
    chk("we", 32'(dmem_we_out), (kind == 2) ? 32'd1 : 32'd0);
    chk("addr", dmem_addr_out, addr - 32'(a));
    chk("be", 32'(dmem_be_out), ref_be(sz, a));
    if (kind == 2) chk("wdata", dmem_wdata_out, ref_wdata(sz, data));
    timed_out = 1'b0;
    for (int i = 0; i < TO; i++) begin
      if (i == lat) begin
        dmem_ack_in   = 1'b1;
        dmem_rdata_in = rdat;
        #1 chk("stall_on_ack", 32'(stall_out), 32'd0);
        break;
      end
      if (i == TO - 1) begin
        #1 chk("stall_at_timeout", 32'(stall_out), 32'd0);
        timed_out = 1'b1;
        break;
      end
      dmem_rdata_in = $urandom;
      #1;
      chk("stall_wait", 32'(stall_out), 32'd1);
      chk("wb_quiet", 32'(wb_reg_wr_ena_out), 32'd0);
      @(posedge clk); @(negedge clk);
    end
    @(posedge clk); @(negedge clk);
    dmem_ack_in = 1'b0;
    #1;
    chk("req_drop", 32'(dmem_req_out), 32'd0);
    chk("bus_error", 32'(bus_error_out), 32'(timed_out));
    chk("wb_ena_mem", 32'(wb_reg_wr_ena_out), (kind == 1 && !timed_out) ? 32'd1 : 32'd0);
    if (kind == 1 && !timed_out) begin
      chk("wb_load_data", wb_reg_data_out, ref_load(sz, a, sgn, rdat));
      chk("wb_load_addr", 32'(wb_reg_addr_out), 32'(rd));
    end
    chk("stall_after", 32'(stall_out), 32'd0);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_req", 32'(dmem_req_out), 32'd0);
    chk("rst_stall", 32'(stall_out), 32'd0);
    chk("rst_wb_ena", 32'(wb_reg_wr_ena_out), 32'd0);
    chk("rst_fwd_ena", 32'(ex_mem_reg_wr_ena_out), 32'd0);
    chk("rst_wb_data", wb_reg_data_out, 32'd0);
    chk("rst_pulses", 32'({misaligned_out, bus_error_out}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases
    do_op(0, 2'b10, 32'h12345678, 32'h0, 5'd3, 1'b0, 0, 32'h0);
    do_op(1, 2'b10, 32'h00000100, 32'h0, 5'd4, 1'b0, 0, 32'hDEADBEEF);
    do_op(1, 2'b00, 32'h00000103, 32'h0, 5'd5, 1'b1, 3, 32'h80FFFFFF);
    do_op(1, 2'b00, 32'h00000103, 32'h0, 5'd6, 1'b0, 3, 32'h80FFFFFF);
    do_op(2, 2'b01, 32'h00000202, 32'h0000ABCD, 5'd0, 1'b0, 1, 32'h0);
    do_op(1, 2'b10, 32'h00000101, 32'h0, 5'd7, 1'b0, 0, 32'h0);
    do_op(1, 2'b01, 32'h00000305, 32'h0, 5'd8, 1'b1, 0, 32'h0);
    do_op(1, 2'b11, 32'h00000400, 32'h0, 5'd9, 1'b0, 1000, 32'h0);
    do_op(1, 2'b01, 32'h00000402, 32'h0, 5'd10, 1'b1, TO - 1, 32'h8001_0000);

    // Back-to-back: load acked on the edge that captures a store
    drive_op(1, 2'b10, 32'h00000500, 32'h0, 5'd11, 1'b0);
    @(posedge clk); @(negedge clk);
    drive_op(2, 2'b00, 32'h00000601, 32'h000000A5, 5'd0, 1'b0);
    dmem_ack_in   = 1'b1;
    dmem_rdata_in = 32'hCAFEF00D;
    #1 chk("b2b_stall", 32'(stall_out), 32'd0);
    @(posedge clk); @(negedge clk);
    bubble_inputs();
    dmem_ack_in = 1'b0;
    #1;
    chk("b2b_req", 32'(dmem_req_out), 32'd1);
    chk("b2b_we", 32'(dmem_we_out), 32'd1);
    chk("b2b_addr", dmem_addr_out, 32'h00000600);
    chk("b2b_be", 32'(dmem_be_out), 32'h2);
    chk("b2b_wdata", dmem_wdata_out, 32'hA5A5A5A5);
    chk("b2b_wb_ena", 32'(wb_reg_wr_ena_out), 32'd1);
    chk("b2b_wb_data", wb_reg_data_out, 32'hCAFEF00D);
    chk("b2b_wb_addr", 32'(wb_reg_addr_out), 32'd11);
    dmem_ack_in = 1'b1;
    @(posedge clk); @(negedge clk);
    dmem_ack_in = 1'b0;
    #1;
    chk("b2b_done_req", 32'(dmem_req_out), 32'd0);
    chk("b2b_store_no_wb", 32'(wb_reg_wr_ena_out), 32'd0);

    // Reset in the middle of a BUSY access
    drive_op(1, 2'b10, 32'h00000700, 32'h0, 5'd12, 1'b0);
    @(posedge clk); @(negedge clk);
    bubble_inputs();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_req", 32'(dmem_req_out), 32'd0);
    chk("midrst_stall", 32'(stall_out), 32'd0);
    chk("midrst_wb", 32'(wb_reg_wr_ena_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op(0, 2'b00, 32'h0BADF00D, 32'h0, 5'd13, 1'b0, 0, 32'h0);

    // Randomized instruction stream
    for (int n = 0; n < 80; n++) begin
      int kind;
      int lat;
      kind = int'($urandom_range(0, 2));
      lat  = ($urandom_range(0, 9) == 0) ? 100 : int'($urandom_range(0, 4));
      do_op(kind, 2'($urandom_range(0, 3)), $urandom, $urandom,
            5'($urandom_range(0, 31)), 1'($urandom % 2), lat, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
